pool_window_feeder: RTL and testbench

- Initiator-side driver for the 2x2 max-pooling unit. It reads a row-major feature map from a synchronous single-port buffer and assembles true 2x2 windows.
- For each window it drives input1..input4 with a one-cycle enable, waits for maxPoolingDone, and writes the pooled result to an output buffer.
- Sits between the feature-map RAM and the pooling unit in the CNN datapath.

---
 rtl/pool_window_feeder.sv | 226 ++++++++++++++++++++++
 tb/tb_pool_window_feeder.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_window_feeder.sv
// pool_window_feeder
// Walks a row-major IMG_W x IMG_H feature map held in a synchronous
// single-port RAM, gathers each non-overlapping 2x2 window, hands it to the
// max-pooling unit and stores the pooled result in an output buffer.
// A trailing odd column/row is dropped (floor division of the map size).
//
// Optional build macro: POOL_FEED_TIMEOUT_EN
//   Adds a WAIT-state watchdog (TIMEOUT cycles) and a sticky 'err' output.
//   Without it there is no watchdog and WAIT waits indefinitely.
//
// Handshakes:
//   start          : one-cycle pulse, accepted only in IDLE.
//   rd_en/rd_data  : rd_data is valid exactly one cycle after rd_en.
//   enable         : one-cycle strobe; input1..input4 stay stable from that
//                    cycle until the result is taken (or the watchdog fires).
//   maxPoolingDone : level, considered only in cycles after the enable cycle;
//                    output1 is taken in the first such cycle it is high.
//   wr_en          : one-cycle write strobe with wr_addr/wr_data valid.
//   done           : one-cycle pulse after the last write; busy is low in it.
module pool_window_feeder #(
  parameter int DATA_W  = 22,
  parameter int IMG_W   = 4,
  parameter int IMG_H   = 4,
  parameter int ADDR_W  = 4,
  parameter int OADDR_W = 2,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               rd_en,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic [DATA_W-1:0]  rd_data,
  output logic [DATA_W-1:0]  input1,
  output logic [DATA_W-1:0]  input2,
  output logic [DATA_W-1:0]  input3,
  output logic [DATA_W-1:0]  input4,
  output logic               enable,
  input  logic [DATA_W-1:0]  output1,
  input  logic               maxPoolingDone,
  output logic               wr_en,
  output logic [OADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0]  wr_data
`ifdef POOL_FEED_TIMEOUT_EN
  ,
  output logic               err
`endif
);

  // Row/column counters need headroom for the +2 step past the map edge.
  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_WRITE = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_next;

  logic [CNT_W-1:0]    r_row;
  logic [CNT_W-1:0]    r_col;
  logic [1:0]          r_fidx;      // which of the four samples is being read
  logic                r_cap_vld;   // a read was issued last cycle
  logic [1:0]          r_cap_idx;   // slot that last cycle's read belongs to
  logic                r_first;     // current cycle is the WAIT entry cycle
  logic [OADDR_W-1:0]  r_ocnt;
  logic [DATA_W-1:0]   r_in1;
  logic [DATA_W-1:0]   r_in2;
  logic [DATA_W-1:0]   r_in3;
  logic [DATA_W-1:0]   r_in4;
  logic [DATA_W-1:0]   r_wr_data;

  logic                w_row_wrap;
  logic                w_last_win;
  logic [CNT_W-1:0]    w_col_next;
  logic [CNT_W-1:0]    w_row_next;
  logic                w_take;
  int                  w_lin;

`ifdef POOL_FEED_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [WD_W-1:0]     r_wd;
  logic                r_err;
  logic                w_wd_expire;

  assign w_wd_expire = (r_wd == WD_W'(TIMEOUT - 1));
  assign err         = r_err;
`endif

  // The pooling result counts only after the enable cycle.
  assign w_take = (r_state == S_WAIT) && !r_first && maxPoolingDone;

  // Window advance: step two columns; wrap to the next row pair when no full
  // column pair remains, and finish when no full row pair remains.
  always_comb begin
    w_row_wrap = (int'(r_col) + 3 > IMG_W - 1);
    w_col_next = w_row_wrap ? '0 : r_col + CNT_W'(2);
    w_row_next = w_row_wrap ? r_row + CNT_W'(2) : r_row;
    w_last_win = w_row_wrap && (int'(r_row) + 3 > IMG_H - 1);
  end

  // Linear read address of the sample selected by r_fidx:
  // bit0 picks the right column, bit1 picks the lower row.
  always_comb begin
    w_lin = (int'(r_row) + int'(r_fidx[1])) * IMG_W
          + int'(r_col) + int'(r_fidx[0]);
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_FETCH;
      S_FETCH: if (r_fidx == 2'd3) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT: begin
        if (w_take) w_next = S_WRITE;
`ifdef POOL_FEED_TIMEOUT_EN
        else if (w_wd_expire) w_next = S_FIN;
`endif
      end
      S_WRITE: w_next = w_last_win ? S_FIN : S_FETCH;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register; reset aborts any pass in progress.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Datapath: counters, sample capture, result latch and watchdog.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_row     <= '0;
      r_col     <= '0;
      r_fidx    <= '0;
      r_cap_vld <= 1'b0;
      r_cap_idx <= '0;
      r_first   <= 1'b0;
      r_ocnt    <= '0;
      r_in1     <= '0;
      r_in2     <= '0;
      r_in3     <= '0;
      r_in4     <= '0;
      r_wr_data <= '0;
`ifdef POOL_FEED_TIMEOUT_EN
      r_wd      <= '0;
      r_err     <= 1'b0;
`endif
    end else begin
      // Read data returns one cycle after the strobe; steer it by slot.
      r_cap_vld <= (r_state == S_FETCH);
      r_cap_idx <= r_fidx;
      if (r_cap_vld) begin
        case (r_cap_idx)
          2'd0:    r_in1 <= rd_data;
          2'd1:    r_in2 <= rd_data;
          2'd2:    r_in3 <= rd_data;
          default: r_in4 <= rd_data;
        endcase
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_row  <= '0;
            r_col  <= '0;
            r_ocnt <= '0;
            r_fidx <= '0;
`ifdef POOL_FEED_TIMEOUT_EN
            r_err  <= 1'b0;
`endif
          end
        end
        S_FETCH: r_fidx <= r_fidx + 2'd1;
        S_ISSUE: begin
          r_first <= 1'b1;
`ifdef POOL_FEED_TIMEOUT_EN
          r_wd    <= '0;
`endif
        end
        S_WAIT: begin
          r_first <= 1'b0;
          if (w_take) r_wr_data <= output1;
`ifdef POOL_FEED_TIMEOUT_EN
          else if (w_wd_expire) r_err <= 1'b1;
          else r_wd <= r_wd + WD_W'(1);
`endif
        end
        S_WRITE: begin
          r_ocnt <= r_ocnt + OADDR_W'(1);
          r_col  <= w_col_next;
          r_row  <= w_row_next;
        end
        default: ;
      endcase
    end
  end

  // Strobes are decoded from state so they are mutually exclusive by design.
  always_comb begin
    busy    = (r_state != S_IDLE) && (r_state != S_FIN);
    done    = (r_state == S_FIN);
    rd_en   = (r_state == S_FETCH);
    rd_addr = rd_en ? ADDR_W'(w_lin) : '0;
    enable  = (r_state == S_WAIT) && r_first;
    wr_en   = (r_state == S_WRITE);
    wr_addr = wr_en ? r_ocnt : '0;
    input1  = r_in1;
    input2  = r_in2;
    input3  = r_in3;
    input4  = r_in4;
    wr_data = r_wr_data;
  end

endmodule

// File: tb/tb_pool_window_feeder.sv
// Testbench for pool_window_feeder: a 4x4 instance (TIMEOUT=8) and a 5x5
// instance, each with a RAM model and a behavioural 2x2 max-pooling model.
// Expected results come from a window-by-window reference over the map.
module tb_pool_window_feeder;
  localparam int W = 22;
  localparam logic [W-1:0] POISON = 22'h2AAAAA;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst, start, start5;

  // ---------------- 4x4 DUT ----------------
  logic         busy, done, rd_en, enable, wr_en, mpd;
  logic [3:0]   rd_addr;
  logic [1:0]   wr_addr;
  logic [W-1:0] rd_data, in1, in2, in3, in4, output1, wr_data;
`ifdef POOL_FEED_TIMEOUT_EN
  logic err, err5;
`endif

  pool_window_feeder #(.DATA_W(W), .IMG_W(4), .IMG_H(4), .ADDR_W(4), .OADDR_W(2), .TIMEOUT(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .input1(in1), .input2(in2), .input3(in3), .input4(in4), .enable(enable),
    .output1(output1), .maxPoolingDone(mpd),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
`ifdef POOL_FEED_TIMEOUT_EN
    , .err(err)
`endif
  );

  // ---------------- 5x5 DUT ----------------
  logic         busy5, done5, rd_en5, en5, wr_en5, mpd5;
  logic [4:0]   rd_addr5;
  logic [1:0]   wr_addr5;
  logic [W-1:0] rd_data5, i5_1, i5_2, i5_3, i5_4, out5, wr_data5;

  pool_window_feeder #(.DATA_W(W), .IMG_W(5), .IMG_H(5), .ADDR_W(5), .OADDR_W(2), .TIMEOUT(8)) u_dut5 (
    .clk(clk), .rst(rst), .start(start5), .busy(busy5), .done(done5),
    .rd_en(rd_en5), .rd_addr(rd_addr5), .rd_data(rd_data5),
    .input1(i5_1), .input2(i5_2), .input3(i5_3), .input4(i5_4), .enable(en5),
    .output1(out5), .maxPoolingDone(mpd5),
    .wr_en(wr_en5), .wr_addr(wr_addr5), .wr_data(wr_data5)
`ifdef POOL_FEED_TIMEOUT_EN
    , .err(err5)
`endif
  );

  function automatic logic [W-1:0] max4(input logic [W-1:0] a, b, c, d);
    logic [W-1:0] m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // ---------------- RAM and pooling models ----------------
  logic [W-1:0] mem  [16];
  logic [W-1:0] mem5 [25];
  always @(posedge clk) if (rd_en)  rd_data  <= mem[rd_addr];
  always @(posedge clk) if (rd_en5) rd_data5 <= mem5[rd_addr5];

  int           pool_delay = 1;
  bit           early_hold = 1'b0;
  int           skip_win   = -1;
  int           pool_win   = 0;
  int           pd_cnt     = 0;
  logic         pd_q       = 1'b0;
  logic [W-1:0] out_q      = POISON;
  logic [W-1:0] pend_val   = '0;

  // Pooling unit for the 4x4 DUT: answers pool_delay cycles after enable,
  // shows POISON whenever the result is not valid, and can stay silent.
  always @(posedge clk) begin
    if (rst) begin
      pd_cnt <= 0; pd_q <= 1'b0; out_q <= POISON;
    end else if (enable) begin
      pend_val <= max4(in1, in2, in3, in4);
      if (pool_win == skip_win) begin
        pd_cnt <= 0; pd_q <= 1'b0; out_q <= POISON;
      end else if (pool_delay == 1) begin
        pd_cnt <= 0; pd_q <= 1'b1; out_q <= max4(in1, in2, in3, in4);
      end else begin
        pd_cnt <= pool_delay - 1; pd_q <= 1'b0; out_q <= POISON;
      end
      pool_win = pool_win + 1;
    end else if (pd_cnt == 1) begin
      pd_cnt <= 0; pd_q <= 1'b1; out_q <= pend_val;
    end else begin
      if (pd_cnt > 1) pd_cnt <= pd_cnt - 1;
      pd_q <= 1'b0; out_q <= POISON;
    end
  end
  assign mpd     = pd_q | (early_hold & enable);
  assign output1 = out_q;

  // Pooling unit for the 5x5 DUT: fixed one-cycle response.
  logic         mpd5_q = 1'b0;
  always @(posedge clk) begin
    if (rst || !en5) begin mpd5_q <= 1'b0; out5 <= POISON; end
    else begin mpd5_q <= 1'b1; out5 <= max4(i5_1, i5_2, i5_3, i5_4); end
  end
  assign mpd5 = mpd5_q;

  // ---------------- monitors ----------------
  logic [W-1:0]   act_wr_q[$];
  logic [1:0]     act_wa_q[$];
  int             wr_cyc_q[$];
  int             rd_q[$];
  int             rd_cyc_q[$];
  logic [4*W-1:0] win_q[$];
  int             en_cyc_q[$];
  int             excl_err = 0;
  int             stab_err = 0;
  bit             watching = 1'b0;
  logic [4*W-1:0] snap;
  logic [W-1:0]   w5_q[$];
  int             rd5_q[$];

  always @(negedge clk) begin
    if (wr_en) begin act_wr_q.push_back(wr_data); act_wa_q.push_back(wr_addr); wr_cyc_q.push_back(cyc); end
    if (rd_en) begin rd_q.push_back(int'(rd_addr)); rd_cyc_q.push_back(cyc); end
    if (enable) begin
      win_q.push_back({in1, in2, in3, in4}); en_cyc_q.push_back(cyc);
      snap = {in1, in2, in3, in4}; watching = 1'b1;
    end else if (watching) begin
      if ({in1, in2, in3, in4} !== snap) stab_err++;
      if (wr_en || done || !busy) watching = 1'b0;
    end
    if (int'(rd_en) + int'(enable) + int'(wr_en) > 1) excl_err++;
    if (wr_en5) w5_q.push_back(wr_data5);
    if (rd_en5) rd5_q.push_back(int'(rd_addr5));
  end

  // ---------------- reference model / scoreboard ----------------
  logic [W-1:0]   ref_map[25];
  logic [W-1:0]   exp_q[$];
  logic [4*W-1:0] exp_win_q[$];
  int             exp_rd_q[$];
  int             n_chk = 0;
  int             n_pass = 0;

  // Every full 2x2 window in row-major window order; odd edges are dropped.
  task automatic build_expect(input int iw, input int ih);
    logic [W-1:0] a, b, c, d;
    exp_q.delete(); exp_win_q.delete(); exp_rd_q.delete();
    for (int r = 0; r + 1 < ih; r += 2)
      for (int col = 0; col + 1 < iw; col += 2) begin
        a = ref_map[r*iw + col];       b = ref_map[r*iw + col + 1];
        c = ref_map[(r+1)*iw + col];   d = ref_map[(r+1)*iw + col + 1];
        exp_win_q.push_back({a, b, c, d});
        exp_q.push_back(max4(a, b, c, d));
        exp_rd_q.push_back(r*iw + col);       exp_rd_q.push_back(r*iw + col + 1);
        exp_rd_q.push_back((r+1)*iw + col);   exp_rd_q.push_back((r+1)*iw + col + 1);
      end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_mon();
    act_wr_q.delete(); act_wa_q.delete(); wr_cyc_q.delete();
    rd_q.delete(); rd_cyc_q.delete(); win_q.delete(); en_cyc_q.delete();
    w5_q.delete(); rd5_q.delete();
    excl_err = 0; stab_err = 0; watching = 1'b0; pool_win = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int dcyc);
    dcyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin dcyc = cyc; break; end
    end
  endtask

  task automatic load_map(input int mode);
    for (int i = 0; i < 16; i++)
      mem[i] = (mode == 0) ? W'(i) : (mode == 1) ? W'(15 - i) : W'($urandom);
    foreach (mem[i]) ref_map[i] = mem[i];
    build_expect(4, 4);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start5 = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({busy, done, rd_en, enable, wr_en} !== 5'b0) $display("FAIL reset_strobes: got %b want 00000", {busy, done, rd_en, enable, wr_en});
    else n_pass++;
    n_chk++;
    if ({rd_addr, wr_addr, wr_data} !== '0) $display("FAIL reset_addr_data: got rd_addr %0d wr_addr %0d wr_data %0d want 0", rd_addr, wr_addr, wr_data);
    else n_pass++;
    n_chk++;
    if ({in1, in2, in3, in4} !== '0) $display("FAIL reset_inputs: got %h want 0", {in1, in2, in3, in4});
    else n_pass++;
`ifdef POOL_FEED_TIMEOUT_EN
    n_chk++;
    if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else n_pass++;
`endif
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_ascending();
    int dcyc;
    bit bad;
    load_map(0); pool_delay = 1; early_hold = 1'b0; skip_win = -1;
    clear_mon();
    pulse_start();
    n_chk++;
    if (busy !== 1'b1) $display("FAIL asc_busy_after_start: got %b want 1", busy); else n_pass++;
    wait_done(300, dcyc);
    n_chk++;
    if (dcyc < 0) $display("FAIL asc_done_timeout: no done within 300 cycles"); else n_pass++;
    n_chk++;
    if (busy !== 1'b0) $display("FAIL asc_busy_in_done: got %b want 0", busy); else n_pass++;
    n_chk++;
    if (act_wr_q.size() != 4) $display("FAIL asc_wr_count: got %0d want 4", act_wr_q.size()); else n_pass++;
    foreach (exp_q[i]) begin
      n_chk++;
      if (i >= act_wr_q.size()) $display("FAIL asc_wr%0d: missing, want %0d", i, exp_q[i]);
      else if (act_wr_q[i] !== exp_q[i] || act_wa_q[i] !== 2'(i))
        $display("FAIL asc_wr%0d: got addr %0d data %0d want addr %0d data %0d", i, act_wa_q[i], act_wr_q[i], i, exp_q[i]);
      else n_pass++;
    end
    n_chk++;
    if (wr_cyc_q.size() == 0 || dcyc != wr_cyc_q[$] + 1) $display("FAIL asc_done_timing: done at %0d, last write at %0d", dcyc, (wr_cyc_q.size() > 0) ? wr_cyc_q[$] : -1);
    else n_pass++;
    n_chk++;
    if (wr_cyc_q.size() == 0 || rd_cyc_q.size() == 0 || wr_cyc_q[0] - rd_cyc_q[0] != 7)
      $display("FAIL asc_latency: got %0d want 7", (wr_cyc_q.size() > 0 && rd_cyc_q.size() > 0) ? wr_cyc_q[0] - rd_cyc_q[0] : -1);
    else n_pass++;
    bad = (rd_q.size() != exp_rd_q.size());
    if (!bad) foreach (rd_q[i]) if (rd_q[i] != exp_rd_q[i]) bad = 1'b1;
    n_chk++;
    if (bad) $display("FAIL asc_rd_sequence: got %0d reads, first %0d, want %0d reads", rd_q.size(), (rd_q.size() > 0) ? rd_q[0] : -1, exp_rd_q.size());
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if ({busy, done} !== 2'b00) $display("FAIL asc_after_done: got busy %b done %b want 0 0", busy, done); else n_pass++;
    n_chk++;
    if (excl_err != 0) $display("FAIL asc_strobe_overlap: got %0d overlaps want 0", excl_err); else n_pass++;
  endtask

  task automatic test_descending();
    int dcyc;
    load_map(1); pool_delay = 1; early_hold = 1'b0; skip_win = -1;
    clear_mon();
    pulse_start();
    wait_done(300, dcyc);
    n_chk++;
    if (dcyc < 0 || act_wr_q.size() != 4) $display("FAIL desc_wr_count: got %0d want 4 (done cycle %0d)", act_wr_q.size(), dcyc); else n_pass++;
    foreach (exp_q[i]) begin
      n_chk++;
      if (i >= act_wr_q.size()) $display("FAIL desc_wr%0d: missing, want %0d", i, exp_q[i]);
      else if (act_wr_q[i] !== exp_q[i] || act_wa_q[i] !== 2'(i))
        $display("FAIL desc_wr%0d: got addr %0d data %0d want addr %0d data %0d", i, act_wa_q[i], act_wr_q[i], i, exp_q[i]);
      else n_pass++;
    end
    foreach (exp_win_q[i]) begin
      n_chk++;
      if (i >= win_q.size()) $display("FAIL desc_win%0d: missing, want %h", i, exp_win_q[i]);
      else if (win_q[i] !== exp_win_q[i]) $display("FAIL desc_win%0d: got %h want %h", i, win_q[i], exp_win_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_delayed_done();
    int dcyc;
    load_map(2); pool_delay = 5; early_hold = 1'b1; skip_win = -1;
    clear_mon();
    pulse_start();
    wait_done(400, dcyc);
    n_chk++;
    if (dcyc < 0 || act_wr_q.size() != 4 || win_q.size() != 4)
      $display("FAIL dly_counts: got %0d writes %0d windows want 4 4 (done cycle %0d)", act_wr_q.size(), win_q.size(), dcyc);
    else n_pass++;
    foreach (exp_q[i]) begin
      n_chk++;
      if (i >= act_wr_q.size()) $display("FAIL dly_wr%0d: missing, want %0d", i, exp_q[i]);
      else if (act_wr_q[i] !== exp_q[i] || act_wa_q[i] !== 2'(i))
        $display("FAIL dly_wr%0d: got addr %0d data %0d want addr %0d data %0d", i, act_wa_q[i], act_wr_q[i], i, exp_q[i]);
      else n_pass++;
    end
    n_chk++;
    if (stab_err != 0) $display("FAIL dly_inputs_stable: got %0d changes want 0", stab_err); else n_pass++;
    n_chk++;
    if (en_cyc_q.size() < 1 || wr_cyc_q.size() < 1 || wr_cyc_q[0] - en_cyc_q[0] != 6)
      $display("FAIL dly_write_timing: got %0d want 6", (en_cyc_q.size() > 0 && wr_cyc_q.size() > 0) ? wr_cyc_q[0] - en_cyc_q[0] : -1);
    else n_pass++;
    early_hold = 1'b0;
  endtask

  task automatic test_abort_restart();
    int  dcyc;
    int  en_seen;
    bit  pulsed;
    bit  busy_dropped;
    load_map(2); pool_delay = 5; early_hold = 1'b0; skip_win = -1;
    clear_mon();
    pulse_start();
    en_seen = 0; pulsed = 1'b0; busy_dropped = 1'b0;
    for (int i = 0; i < 400 && en_seen < 3; i++) begin
      @(negedge clk);
      if (start) start = 1'b0;
      if (!busy) busy_dropped = 1'b1;
      if (wr_en && !pulsed) begin start = 1'b1; pulsed = 1'b1; end
      if (enable) en_seen++;
    end
    start = 1'b0;
    n_chk++;
    if (en_seen != 3 || busy_dropped) $display("FAIL abort_reach_wait3: got %0d enables busy_dropped %b want 3 0", en_seen, busy_dropped); else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({busy, done, rd_en, enable, wr_en, rd_addr, wr_addr, wr_data, in1, in2, in3, in4} !== '0)
      $display("FAIL abort_outputs_zero: got busy %b wr_en %b wr_data %0d in1 %0d want 0", busy, wr_en, wr_data, in1);
    else n_pass++;
    @(negedge clk) rst = 1'b0;
    repeat (10) @(negedge clk);
    n_chk++;
    if (act_wr_q.size() != 2) $display("FAIL abort_wr_count: got %0d want 2", act_wr_q.size()); else n_pass++;
    for (int i = 0; i < 2; i++) begin
      n_chk++;
      if (i >= act_wr_q.size()) $display("FAIL abort_wr%0d: missing, want %0d", i, exp_q[i]);
      else if (act_wr_q[i] !== exp_q[i] || act_wa_q[i] !== 2'(i))
        $display("FAIL abort_wr%0d: got addr %0d data %0d want addr %0d data %0d", i, act_wa_q[i], act_wr_q[i], i, exp_q[i]);
      else n_pass++;
    end
    clear_mon();
    pulse_start();
    wait_done(400, dcyc);
    n_chk++;
    if (dcyc < 0 || act_wr_q.size() != 4) $display("FAIL restart_wr_count: got %0d want 4 (done cycle %0d)", act_wr_q.size(), dcyc); else n_pass++;
    foreach (exp_q[i]) begin
      n_chk++;
      if (i >= act_wr_q.size()) $display("FAIL restart_wr%0d: missing, want %0d", i, exp_q[i]);
      else if (act_wr_q[i] !== exp_q[i] || act_wa_q[i] !== 2'(i))
        $display("FAIL restart_wr%0d: got addr %0d data %0d want addr %0d data %0d", i, act_wa_q[i], act_wr_q[i], i, exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_random_maps();
    int dcyc;
    for (int p = 0; p < 4; p++) begin
      load_map(2);
      pool_delay = $urandom_range(1, 6);
      early_hold = 1'($urandom_range(0, 1));
      skip_win = -1;
      clear_mon();
      pulse_start();
      wait_done(400, dcyc);
      n_chk++;
      if (dcyc < 0 || act_wr_q.size() != 4) $display("FAIL rnd%0d_wr_count: got %0d want 4 (delay %0d)", p, act_wr_q.size(), pool_delay); else n_pass++;
      foreach (exp_q[i]) begin
        n_chk++;
        if (i >= act_wr_q.size()) $display("FAIL rnd%0d_wr%0d: missing, want %0d", p, i, exp_q[i]);
        else if (act_wr_q[i] !== exp_q[i] || act_wa_q[i] !== 2'(i))
          $display("FAIL rnd%0d_wr%0d: got addr %0d data %0d want addr %0d data %0d", p, i, act_wa_q[i], act_wr_q[i], i, exp_q[i]);
        else n_pass++;
      end
      n_chk++;
      if (excl_err != 0 || stab_err != 0) $display("FAIL rnd%0d_strobes: got overlaps %0d input changes %0d want 0 0", p, excl_err, stab_err); else n_pass++;
    end
    early_hold = 1'b0;
  endtask

  task automatic test_odd_size();
    int  dcyc;
    int  bad_rd;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 25; i++) mem5[i] = (p == 0) ? W'(i) : W'($urandom);
      foreach (mem5[i]) ref_map[i] = mem5[i];
      build_expect(5, 5);
      clear_mon();
      @(negedge clk) start5 = 1'b1;
      @(negedge clk) start5 = 1'b0;
      dcyc = -1;
      for (int i = 0; i < 300; i++) begin
        @(negedge clk);
        if (done5) begin dcyc = cyc; break; end
      end
      n_chk++;
      if (dcyc < 0 || w5_q.size() != 4) $display("FAIL odd%0d_wr_count: got %0d want 4 (done cycle %0d)", p, w5_q.size(), dcyc); else n_pass++;
      foreach (exp_q[i]) begin
        n_chk++;
        if (i >= w5_q.size()) $display("FAIL odd%0d_wr%0d: missing, want %0d", p, i, exp_q[i]);
        else if (w5_q[i] !== exp_q[i]) $display("FAIL odd%0d_wr%0d: got %0d want %0d", p, i, w5_q[i], exp_q[i]);
        else n_pass++;
      end
      bad_rd = 0;
      foreach (rd5_q[i]) if ((rd5_q[i] % 5) == 4 || rd5_q[i] >= 20) bad_rd++;
      n_chk++;
      if (bad_rd != 0 || rd5_q.size() != 16) $display("FAIL odd%0d_reads: got %0d edge reads of %0d total want 0 of 16", p, bad_rd, rd5_q.size()); else n_pass++;
    end
  endtask

`ifdef POOL_FEED_TIMEOUT_EN
  task automatic test_timeout();
    int dcyc;
    load_map(0); pool_delay = 1; early_hold = 1'b0; skip_win = 1;
    clear_mon();
    pulse_start();
    wait_done(400, dcyc);
    n_chk++;
    if (dcyc < 0 || act_wr_q.size() != 1) $display("FAIL wd_wr_count: got %0d want 1 (done cycle %0d)", act_wr_q.size(), dcyc); else n_pass++;
    n_chk++;
    if (act_wr_q.size() < 1 || act_wr_q[0] !== exp_q[0]) $display("FAIL wd_wr0: got %0d want %0d", (act_wr_q.size() > 0) ? act_wr_q[0] : '0, exp_q[0]); else n_pass++;
    n_chk++;
    if (err !== 1'b1) $display("FAIL wd_err_set: got %b want 1", err); else n_pass++;
    n_chk++;
    if (en_cyc_q.size() != 2 || dcyc - en_cyc_q[1] != 8)
      $display("FAIL wd_wait_cycles: got %0d want 8", (en_cyc_q.size() > 1) ? dcyc - en_cyc_q[1] : -1);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_chk++;
    if (err !== 1'b1) $display("FAIL wd_err_sticky: got %b want 1", err); else n_pass++;
    skip_win = -1;
    clear_mon();
    pulse_start();
    n_chk++;
    if (err !== 1'b0) $display("FAIL wd_err_clear: got %b want 0", err); else n_pass++;
    wait_done(400, dcyc);
    n_chk++;
    if (dcyc < 0 || act_wr_q.size() != 4 || err !== 1'b0) $display("FAIL wd_clean_pass: got %0d writes err %b want 4 0", act_wr_q.size(), err); else n_pass++;
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1; start = 1'b0; start5 = 1'b0;
    test_reset();
    test_ascending();
    test_descending();
    test_delayed_done();
    test_abort_restart();
    test_random_maps();
    test_odd_size();
`ifdef POOL_FEED_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
